// File: rtl/ms6205_screen_responder.sv
// MS6205 display-side responder: bus slave, ROWS x 16 character RAM and registered scan port.
// Optional build macro MS6205_AUTOINC_EN: the cursor advances one cell after every accepted data write.
module ms6205_screen_responder #(
  parameter int         COLUMNS     = 16,
  parameter int         ROWS        = 10,
  parameter int         BUSY_CYCLES = 4,
  parameter logic [6:0] BLANK_CHAR  = 7'h20
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       write_addr,
  input  logic       write_data,
  input  logic       marker,
  output logic       ready,
  input  logic [7:0] scan_addr,
  output logic [6:0] scan_char,
  output logic       scan_cursor,
  output logic [7:0] cursor,
  output logic       err
);

  localparam int         CELLS    = ROWS * COLUMNS;
  localparam logic [8:0] CELLS_W  = 9'(CELLS);
  localparam logic [4:0] ROWS_W   = 5'(ROWS);
  localparam logic [3:0] BUSY_W   = 4'(BUSY_CYCLES);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t     r_state;
  logic [8:0] r_clr_ptr;
  logic [3:0] r_busy_cnt;
  logic       r_wa_d;
  logic       r_wd_d;
  logic [7:0] r_cursor;
  logic       r_ready;
  logic       r_err;
  logic [6:0] r_scan_char;
  logic       r_scan_cursor;
  logic [6:0] r_ram [0:CELLS-1];

  logic       w_wa_edge;
  logic       w_wd_edge;
  logic [7:0] w_new_cur;
  logic       w_row_ok;
  logic       w_accept;
  logic       w_reject;
  logic [7:0] w_cur_after;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [6:0] w_wdata;
  logic       w_unused_data7;

  assign w_unused_data7 = data[7];

`ifdef MS6205_AUTOINC_EN
  // Row-major successor of a cell; the last valid cell wraps to the origin.
  function automatic logic [7:0] next_cell(input logic [7:0] c);
    logic [7:0] n;
    if (c[3:0] != 4'hF) begin
      n = c + 8'd1;
    end else if (c[7:4] == LAST_ROW) begin
      n = 8'h00;
    end else begin
      n = {c[7:4] + 4'd1, 4'h0};
    end
    return n;
  endfunction
`endif

  assign w_wa_edge = write_addr & ~r_wa_d;
  assign w_wd_edge = write_data & ~r_wd_d;
  // A coincident address edge takes effect before the data write and its row check.
  assign w_new_cur = w_wa_edge ? address : r_cursor;
  assign w_row_ok  = ({1'b0, w_new_cur[7:4]} < ROWS_W);
  assign w_accept  = (r_state == S_IDLE) && w_wd_edge && w_row_ok;
  assign w_reject  = ((r_state == S_IDLE) && w_wd_edge && !w_row_ok) ||
                     ((r_state == S_BUSY) && (w_wa_edge || w_wd_edge));

`ifdef MS6205_AUTOINC_EN
  assign w_cur_after = w_accept ? next_cell(w_new_cur) : w_new_cur;
`else
  assign w_cur_after = w_new_cur;
`endif

  // RAM write port: blank fill while clearing, bus data when a write is accepted.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 8'h00;
    w_wdata = BLANK_CHAR;
    if ((r_state == S_CLEAR) && (r_clr_ptr < CELLS_W)) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr[7:0];
    end else if (w_accept) begin
      w_we    = 1'b1;
      w_waddr = w_new_cur;
      w_wdata = data[6:0];
    end else begin
      w_we    = 1'b0;
    end
  end

  // Character RAM storage; contents are rebuilt by the clear sequence after reset.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_ram[w_waddr] <= w_wdata;
    end
  end

  // Control FSM with strobe edge detectors, cursor, ready and err.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_ptr  <= 9'd0;
      r_busy_cnt <= 4'd0;
      r_wa_d     <= 1'b0;
      r_wd_d     <= 1'b0;
      r_cursor   <= 8'h00;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wa_d <= write_addr;
      r_wd_d <= write_data;
      r_err  <= w_reject;
      case (r_state)
        S_CLEAR: begin
          // One spare cycle after the last cell so ready rises at CELLS+1.
          if (r_clr_ptr == CELLS_W) begin
            r_state   <= S_IDLE;
            r_clr_ptr <= 9'd0;
            r_ready   <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + 9'd1;
            r_ready   <= 1'b0;
          end
        end
        S_IDLE: begin
          r_cursor <= w_cur_after;
          if (w_accept && (BUSY_W != 4'd0)) begin
            r_state    <= S_BUSY;
            r_busy_cnt <= BUSY_W;
            r_ready    <= 1'b0;
          end else begin
            r_ready    <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_busy_cnt <= 4'd1) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_busy_cnt <= r_busy_cnt - 4'd1;
            r_ready    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_ptr <= 9'd0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Registered scan port; rows past the screen read as blank.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_scan_char   <= BLANK_CHAR;
      r_scan_cursor <= 1'b0;
    end else begin
      if ({1'b0, scan_addr[7:4]} < ROWS_W) begin
        r_scan_char <= r_ram[scan_addr];
      end else begin
        r_scan_char <= BLANK_CHAR;
      end
      r_scan_cursor <= (scan_addr == r_cursor) && marker;
    end
  end

  assign ready       = r_ready;
  assign err         = r_err;
  assign cursor      = r_cursor;
  assign scan_char   = r_scan_char;
  assign scan_cursor = r_scan_cursor;

endmodule

// File: tb/tb_ms6205_screen_responder.sv
// Directed, table-driven bench for ms6205_screen_responder (default parameters).
module tb_ms6205_screen_responder;

`ifdef MS6205_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       Clk;
  logic       Rst_n;
  logic [7:0] address;
  logic [7:0] data;
  logic       write_addr;
  logic       write_data;
  logic       marker;
  logic       ready;
  logic [7:0] scan_addr;
  logic [6:0] scan_char;
  logic       scan_cursor;
  logic [7:0] cursor;
  logic       err;

  int n_vec;
  int n_fail;

  ms6205_screen_responder dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .address     (address),
    .data        (data),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .marker      (marker),
    .ready       (ready),
    .scan_addr   (scan_addr),
    .scan_char   (scan_char),
    .scan_cursor (scan_cursor),
    .cursor      (cursor),
    .err         (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       wa;
    logic       wd;
    logic       mk;
    logic [7:0] addr;
    logic [7:0] dat;
    logic [7:0] scan;
    logic       e_ready;
    logic       e_err;
    logic [6:0] e_char;
    logic       e_scur;
    logic [7:0] e_cur;
  } vec_t;

  vec_t vt [16];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds reset, checks reset values, releases and times the clear sequence.
  task automatic reset_and_clear(input bit inject);
    int  rise;
    bit  seen_err;
    Rst_n = 1'b0;
    write_addr = 1'b0;
    write_data = 1'b0;
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_cursor", cursor, 8'h00);
    chk("rst_scan_char", scan_char, 7'h20);
    chk("rst_scan_cursor", scan_cursor, 1'b0);
    chk("rst_err", err, 1'b0);
    step();
    step();
    Rst_n = 1'b1;
    rise = 0;
    seen_err = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (inject && k == 50) begin data = 8'h33; write_data = 1'b1; end
      if (inject && k == 51) write_data = 1'b0;
      if (inject && k == 60) begin address = 8'h55; write_addr = 1'b1; end
      if (inject && k == 61) write_addr = 1'b0;
      step();
      if (err) seen_err = 1'b1;
      if (ready) begin
        rise = k;
        break;
      end
    end
    chk("ready_rise_cycle", rise, 161);
    chk("clear_no_err", seen_err, 1'b0);
    chk("clear_cursor", cursor, 8'h00);
  endtask

  initial begin
    logic [7:0] c23;
    logic [7:0] c10;
    logic [7:0] wcell;
    n_vec = 0;
    n_fail = 0;
    address = 8'h00;
    data = 8'h00;
    write_addr = 1'b0;
    write_data = 1'b0;
    marker = 1'b0;
    scan_addr = 8'h00;
    Rst_n = 1'b0;
    c23 = AI ? 8'h24 : 8'h23;
    c10 = AI ? 8'h11 : 8'h10;

    //          wa    wd    mk    addr   dat    scan  | rdy  err   char   scur          cur
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 7'h20, 1'b0,         8'h23};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 7'h20, 1'b0,         8'h23};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h23, 8'hC1, 8'h23, 1'b0, 1'b0, 7'h20, 1'b0,         c23};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h23, 8'hC1, 8'h23, 1'b0, 1'b0, 7'h41, 1'b0,         c23};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h23, 8'h55, 8'h23, 1'b0, 1'b1, 7'h41, 1'b0,         c23};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h23, 8'h55, 8'h23, 1'b0, 1'b0, 7'h41, 1'b0,         c23};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h23, 8'h55, 8'h23, 1'b1, 1'b0, 7'h41, 1'b0,         c23};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h23, 8'h55, 8'h23, 1'b1, 1'b0, 7'h41, logic'(!AI), c23};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'hA0, 1'b1, 1'b0, 7'h20, 1'b0,         8'hA5};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h42, 8'hA5, 1'b1, 1'b1, 7'h20, 1'b0,         8'hA5};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h42, 8'hA5, 1'b1, 1'b0, 7'h20, 1'b0,         8'hA5};
    vt[11] = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h5A, 8'h10, 1'b0, 1'b0, 7'h20, 1'b0,         c10};
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, 8'h10, 1'b0, 1'b0, 7'h5A, logic'(!AI), c10};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h5A, 8'h10, 1'b0, 1'b0, 7'h5A, 1'b0,         c10};
    vt[14] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h5A, 8'h10, 1'b0, 1'b0, 7'h5A, 1'b0,         c10};
    vt[15] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h5A, 8'h10, 1'b1, 1'b0, 7'h5A, 1'b0,         c10};

    step();
    reset_and_clear(1'b1);

    // Every cell plus the first out-of-range address reads blank after clearing.
    for (int a = 0; a <= 8'hA0; a++) begin
      scan_addr = 8'(a);
      step();
      chk($sformatf("blank_scan_%02h", a), scan_char, 7'h20);
    end

    for (int i = 0; i < 16; i++) begin
      write_addr = vt[i].wa;
      write_data = vt[i].wd;
      marker     = vt[i].mk;
      address    = vt[i].addr;
      data       = vt[i].dat;
      scan_addr  = vt[i].scan;
      step();
      chk($sformatf("v%0d_ready", i), ready, vt[i].e_ready);
      chk($sformatf("v%0d_err", i), err, vt[i].e_err);
      chk($sformatf("v%0d_scan_char", i), scan_char, vt[i].e_char);
      chk($sformatf("v%0d_scan_cursor", i), scan_cursor, vt[i].e_scur);
      chk($sformatf("v%0d_cursor", i), cursor, vt[i].e_cur);
    end
    write_addr = 1'b0;
    write_data = 1'b0;
    marker = 1'b0;

    // Cursor wrap from the last cell, then from the end of a row.
    address = 8'h9F; write_addr = 1'b1; step();
    write_addr = 1'b0; step();
    data = 8'h11; write_data = 1'b1; step();
    chk("wrap_last_cursor", cursor, AI ? 8'h00 : 8'h9F);
    write_data = 1'b0; scan_addr = 8'h9F; step();
    chk("wrap_last_ram", scan_char, 7'h11);
    step(); step(); step();
    chk("wrap_last_ready", ready, 1'b1);
    address = 8'h0F; write_addr = 1'b1; step();
    write_addr = 1'b0; step();
    data = 8'h12; write_data = 1'b1; step();
    chk("wrap_row_cursor", cursor, AI ? 8'h10 : 8'h0F);
    write_data = 1'b0;
    step(); step(); step(); step();
    chk("wrap_row_ready", ready, 1'b1);

    // Reset in the middle of a busy period restarts the clear sequence.
    wcell = cursor;
    data = 8'h7E; write_data = 1'b1; step();
    chk("midrst_busy", ready, 1'b0);
    write_data = 1'b0;
    reset_and_clear(1'b0);
    scan_addr = wcell; step();
    chk("midrst_cell_blank", scan_char, 7'h20);
    scan_addr = 8'h23; step();
    chk("midrst_23_blank", scan_char, 7'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
